alu_writeback_queue: RTL and testbench

//  Buffers completed results from the scalar ALU (ex_update) and presents them to the ROB/CDB writeback port

---
 rtl/alu_writeback_queue_pkg.sv | 21 ++
 rtl/alu_writeback_queue_if.sv | 12 +
 rtl/alu_writeback_queue_wb_fifo_ctrl.sv | 76 +++++++
 rtl/alu_writeback_queue.sv | 66 ++++++
 tb/tb_alu_writeback_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_writeback_queue_pkg.sv
// Shared core types for the ALU writeback path: the ex_update result record
// and the default sizing of the writeback queue.
package alu_writeback_queue_pkg;

  localparam int XLEN           = 32;
  localparam int R_ADDR         = 6;
  localparam int ROB_INDEX_BITS = 3;
  localparam int CAUSE_W        = 5;
  localparam int WB_Q_DEPTH     = 4;

  // One completed ALU result as seen on the CDB.
  typedef struct packed {
    logic                      valid;
    logic [R_ADDR-1:0]         destination;
    logic [ROB_INDEX_BITS-1:0] ticket;
    logic [XLEN-1:0]           data;
    logic                      valid_exception;
    logic [CAUSE_W-1:0]        cause;
  } ex_update;

endpackage

// File: rtl/alu_writeback_queue_if.sv
// Result-in / writeback-out bundle of the ALU writeback queue.
// The master side produces results and owns the writeback ready.
interface alu_writeback_queue_if;
  import alu_writeback_queue_pkg::*;

  ex_update fu_update_i;
  ex_update wb_o;
  logic     wb_ready_i;

  modport master (output fu_update_i, output wb_ready_i, input wb_o);
  modport slave  (input fu_update_i, input wb_ready_i, output wb_o);
endinterface

// File: rtl/alu_writeback_queue_wb_fifo_ctrl.sv
// Pointer/occupancy control for the writeback queue: qualifies push and pop,
// tracks wrap-bit pointers, and produces the early busy stall and the
// sticky overflow flag.
module alu_writeback_queue_wb_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_req,
  input  logic                     ready,
  output logic                     wr_en,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  // Occupancy at which free entries drop to SLACK or fewer.
  localparam int BUSY_AT_I = (DEPTH > SLACK) ? (DEPTH - SLACK) : 0;
  localparam logic [PW-1:0] BUSY_AT = BUSY_AT_I[PW-1:0];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] count_nxt;
  logic          full, push, pop, push_ok, drop, busy_nxt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
  assign count = wr_ptr - rd_ptr;

  // A flush discards both the incoming result and the head handshake.
  assign push    = push_req & ~flush;
  assign pop     = ~empty & ready & ~flush;
  // When full, a same-cycle pop frees the slot the tail is about to reuse.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign wr_en  = push_ok;
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Next pointers and next occupancy, which drives the registered busy.
  always_comb begin
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
    busy_nxt  = (count_nxt >= BUSY_AT);
  end

  // Pointer, busy and sticky-overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      busy     <= busy_nxt;
      overflow <= overflow | drop;
    end
  end

endmodule

// File: rtl/alu_writeback_queue.sv
// Writeback queue between the scalar ALU and the ROB/CDB port. The ALU cannot
// be back-pressured, so results are buffered here in arrival order and issue
// is stalled early through busy_o.
module alu_writeback_queue
  import alu_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_Q_DEPTH,
  parameter int SLACK = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  alu_writeback_queue_if.slave    wb_if,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic          wr_en, empty;
  logic [AW-1:0] wr_idx, rd_idx;
  ex_update      entry_in;
  ex_update      mem [DEPTH];

  alu_writeback_queue_wb_fifo_ctrl #(
    .DEPTH (DEPTH),
    .SLACK (SLACK)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_i),
    .push_req (wb_if.fu_update_i.valid),
    .ready    (wb_if.wb_ready_i),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx),
    .empty    (empty),
    .count    (count_o),
    .busy     (busy_o),
    .overflow (overflow_o)
  );

  // Stored entries always carry valid=1; all other fields pass through.
  always_comb begin
    entry_in       = wb_if.fu_update_i;
    entry_in.valid = 1'b1;
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= entry_in;
    end
  end

  // Head presentation; all fields read as zero while the queue is empty.
  always_comb begin
    wb_if.wb_o = '0;
    if (!empty) begin
      wb_if.wb_o       = mem[rd_idx];
      wb_if.wb_o.valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_writeback_queue.sv
// Bench for alu_writeback_queue: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_alu_writeback_queue;
  import alu_writeback_queue_pkg::*;

  localparam int DEPTH = WB_Q_DEPTH;
  localparam int SLACK = 2;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       busy;
  logic [2:0] count;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;
  bit cmp_en     = 0;

  alu_writeback_queue_if wb_if();

  alu_writeback_queue #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .wb_if      (wb_if.slave),
    .busy_o     (busy),
    .count_o    (count),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  ex_update mq[$];
  bit       m_ovf;
  bit       m_pop, m_push;
  ex_update m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && wb_if.wb_ready_i;
      m_push = wb_if.fu_update_i.valid;
      if (m_push && mq.size() == DEPTH && !m_pop) begin
        m_ovf  = 1'b1;
        m_push = 1'b0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        m_e       = wb_if.fu_update_i;
        m_e.valid = 1'b1;
        mq.push_back(m_e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    ex_update exp_wb;
    if (cmp_en) begin
      exp_wb = '0;
      if (mq.size() > 0) exp_wb = mq[0];
      chk("model_wb", 64'(wb_if.wb_o), 64'(exp_wb));
      chk("model_count", 64'(count), 64'(mq.size()));
      chk("model_busy", 64'(busy), 64'((DEPTH - mq.size()) <= SLACK));
      chk("model_ovf", 64'(overflow), 64'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [5:0] d, input logic [2:0] t,
                       input logic [31:0] data, input bit rdy, input bit fl);
    ex_update u;
    u                 = '0;
    u.valid           = v;
    u.destination     = d;
    u.ticket          = t;
    u.data            = data;
    wb_if.fu_update_i = u;
    wb_if.wb_ready_i  = rdy;
    flush             = fl;
  endtask

  logic [31:0] exp4 [4];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    cmp_en = 1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(wb_if.wb_o.valid), 64'd0);

    // Single ADD result flows through with one cycle of latency.
    drive(1, 6'd5, 3'd2, 32'h0000_0007, 1, 0);
    cyc();
    chk("add_valid", 64'(wb_if.wb_o.valid), 64'd1);
    chk("add_dest", 64'(wb_if.wb_o.destination), 64'd5);
    chk("add_ticket", 64'(wb_if.wb_o.ticket), 64'd2);
    chk("add_data", 64'(wb_if.wb_o.data), 64'd7);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("add_empty", 64'(wb_if.wb_o.valid), 64'd0);

    // Fill with no ready, overflow on the fifth push, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 6'(i), 3'(i), 32'(i), 0, 0);
      cyc();
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_busy", 64'(busy), 64'(i >= 2));
    end
    drive(1, 6'd9, 3'd5, 32'd5, 0, 0);
    cyc();
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 64'(wb_if.wb_o.data), 64'(i));
      cyc();
    end
    chk("drain_empty", 64'(count), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of traffic.
    drive(1, 6'd1, 3'd1, 32'hAA, 0, 0);
    cyc();
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(wb_if.wb_o.valid), 64'd0);
    chk("async_data", 64'(wb_if.wb_o.data), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_ovf", 64'(overflow), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'(i), 3'(i), 32'h10 + 32'(i), 0, 0);
      cyc();
    end
    drive(1, 6'd7, 3'd7, 32'h20, 1, 0);
    cyc();
    chk("fullpp_count", 64'(count), 64'd4);
    chk("fullpp_ovf", 64'(overflow), 64'd0);
    exp4[0] = 32'h11; exp4[1] = 32'h12; exp4[2] = 32'h13; exp4[3] = 32'h20;
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_order", 64'(wb_if.wb_o.data), 64'(exp4[i]));
      cyc();
    end

    // Back-to-back push/pop through several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      drive(1, 6'(i), 3'(i), 32'h100 + 32'(i), 1, 0);
      cyc();
      chk("b2b_data", 64'(wb_if.wb_o.data), 64'h100 + 64'(i));
      chk("b2b_count", 64'(count), 64'd1);
    end
    drive(0, 0, 0, 0, 1, 0);
    cyc();

    // Flush with a concurrent push while holding three entries.
    for (int i = 0; i < 5; i++) begin
      drive(1, 6'(i), 3'(i), 32'h30 + 32'(i), 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(1, 6'd3, 3'd3, 32'hDEAD, 0, 1);
    cyc();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(wb_if.wb_o.valid), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd1);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("flush_gone", 64'(wb_if.wb_o.valid), 64'd0);

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 600; i++) begin
      ex_update u;
      u                 = ex_update'({$urandom(), $urandom()});
      u.valid           = ($urandom_range(0, 9) < 6);
      wb_if.fu_update_i = u;
      wb_if.wb_ready_i  = ($urandom_range(0, 9) < 4);
      flush             = ($urandom_range(0, 99) < 3);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    cmp_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
